// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// The ALU imports the ALU_* constants from here as well.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_IALU = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_ILL  = 3'd5
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
  } dec_t;

  localparam dec_t DEC_NONE = '{cls: CLS_ILL, alu_op: ALU_ADD, alu_src: 1'b0,
                                reg_dst: 1'b0, mem_to_reg: 1'b0};

  function automatic logic is_mem_cls(input cls_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class and
// the ALU / write-back controls that go with it.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_unused_fields;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  // Register and immediate fields only matter to the datapath.
  assign w_unused_fields = ^i_instr[25:6];

  always_comb begin
    o_dec = DEC_NONE;
    unique case (w_opcode)
      OP_RTYPE: begin
        o_dec.cls     = CLS_R;
        o_dec.reg_dst = 1'b1;
        unique case (w_funct)
          FN_ADD:  o_dec.alu_op = ALU_ADD;
          FN_SUB:  o_dec.alu_op = ALU_SUB;
          FN_XOR:  o_dec.alu_op = ALU_XOR;
          FN_NOR:  o_dec.alu_op = ALU_NOR;
          FN_OR:   o_dec.alu_op = ALU_OR;
          default: o_dec = DEC_NONE;
        endcase
      end
      OP_ADDI: begin
        o_dec.cls     = CLS_IALU;
        o_dec.alu_op  = ALU_ADD;
        o_dec.alu_src = 1'b1;
      end
      OP_ORI: begin
        o_dec.cls     = CLS_IALU;
        o_dec.alu_op  = ALU_OR;
        o_dec.alu_src = 1'b1;
      end
      OP_XORI: begin
        o_dec.cls     = CLS_IALU;
        o_dec.alu_op  = ALU_XOR;
        o_dec.alu_src = 1'b1;
      end
      OP_LW: begin
        o_dec.cls        = CLS_LW;
        o_dec.alu_op     = ALU_ADD;
        o_dec.alu_src    = 1'b1;
        o_dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        o_dec.cls     = CLS_SW;
        o_dec.alu_op  = ALU_ADD;
        o_dec.alu_src = 1'b1;
      end
      OP_BEQ: begin
        o_dec.cls    = CLS_BEQ;
        o_dec.alu_op = ALU_SUB;
      end
      default: o_dec = DEC_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with decode register and
// retired-instruction counter.
//   state  | meaning
//   FETCH  | wait for instr_valid, latch IR, advance PC
//   DECODE | classify IR; illegal pulses here and returns to FETCH
//   EXEC   | ALU op for R/I/mem address; beq resolves and retires
//   MEM    | hold mem strobe until mem_ready; sw retires here
//   WB     | register-file write and retire
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ir;
  dec_t             r_dec;
  dec_t             w_dec;
  logic [CNT_W-1:0] r_cnt;

  ctrl_decode u_decode (
    .i_instr (r_ir),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_ir    <= '0;
      r_dec   <= DEC_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && instr_valid) r_ir <= instr;
      if (r_state == DECODE) r_dec <= w_dec;
      if (retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (r_state)
      FETCH: begin
        ir_write = instr_valid;
        pc_write = instr_valid;
        if (instr_valid) w_next = DECODE;
      end
      DECODE: begin
        if (w_dec.cls == CLS_ILL) begin
          illegal = 1'b1;
          w_next  = FETCH;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        alu_op  = r_dec.alu_op;
        alu_src = r_dec.alu_src;
        if (r_dec.cls == CLS_BEQ) begin
          // Branch target is only taken when the ALU compare is equal.
          pc_src   = 1'b1;
          pc_write = zero;
          retire   = 1'b1;
          w_next   = FETCH;
        end else if (is_mem_cls(r_dec.cls)) begin
          w_next = MEM;
        end else if (r_dec.cls == CLS_R || r_dec.cls == CLS_IALU) begin
          w_next = WB;
        end else begin
          w_next = FETCH;
        end
      end
      MEM: begin
        alu_op    = r_dec.alu_op;
        alu_src   = r_dec.alu_src;
        mem_read  = (r_dec.cls == CLS_LW);
        mem_write = (r_dec.cls == CLS_SW);
        if (mem_ready) begin
          if (r_dec.cls == CLS_SW) begin
            retire = 1'b1;
            w_next = FETCH;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = r_dec.reg_dst;
        mem_to_reg = r_dec.mem_to_reg;
        retire     = 1'b1;
        w_next     = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl; two instances
// (32-bit and 4-bit counter) share the same stimulus.
module tb_multicycle_ctrl;

  localparam int M_R = 0, M_IALU = 1, M_LW = 2, M_SW = 3, M_BEQ = 4, M_ILL = 5;

  logic        clk = 1'b0;
  logic        rst, instr_valid, zero, mem_ready;
  logic [31:0] instr;

  logic [2:0]  alu_op, alu_op4;
  logic        alu_src, ir_write, pc_write, pc_src, reg_write, reg_dst;
  logic        mem_to_reg, mem_read, mem_write, retire, illegal;
  logic        alu_src4, ir_write4, pc_write4, pc_src4, reg_write4, reg_dst4;
  logic        mem_to_reg4, mem_read4, mem_write4, retire4, illegal4;
  logic [31:0] instr_count;
  logic [3:0]  cnt4;

  int          total = 0;
  int          passed = 0;
  int unsigned cnt_m = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src(alu_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .retire(retire), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op4), .alu_src(alu_src4), .ir_write(ir_write4),
    .pc_write(pc_write4), .pc_src(pc_src4), .reg_write(reg_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .mem_read(mem_read4),
    .mem_write(mem_write4), .retire(retire4), .illegal(illegal4),
    .instr_count(cnt4)
  );

  wire [13:0] obs  = {alu_op, alu_src, ir_write, pc_write, pc_src, reg_write,
                      reg_dst, mem_to_reg, mem_read, mem_write, retire, illegal};
  wire [13:0] obs4 = {alu_op4, alu_src4, ir_write4, pc_write4, pc_src4, reg_write4,
                      reg_dst4, mem_to_reg4, mem_read4, mem_write4, retire4, illegal4};

  function automatic logic [13:0] mk(input logic [2:0] aop, input logic asrc, irw,
                                     pcw, pcs, rw, rd, m2r, mr, mw, ret, ill);
    return {aop, asrc, irw, pcw, pcs, rw, rd, m2r, mr, mw, ret, ill};
  endfunction

  function automatic int model_cls(input logic [31:0] w);
    case (w[31:26])
      6'h00: begin
        if (w[5:0] == 6'h20 || w[5:0] == 6'h22 || w[5:0] == 6'h25 ||
            w[5:0] == 6'h26 || w[5:0] == 6'h27) return M_R;
        return M_ILL;
      end
      6'h08, 6'h0D, 6'h0E: return M_IALU;
      6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h04: return M_BEQ;
      default: return M_ILL;
    endcase
  endfunction

  function automatic logic [2:0] model_aop(input logic [31:0] w);
    case (w[31:26])
      6'h00: case (w[5:0])
               6'h22: return 3'b001;
               6'h26: return 3'b010;
               6'h27: return 3'b011;
               6'h25: return 3'b100;
               default: return 3'b000;
             endcase
      6'h0D: return 3'b100;
      6'h0E: return 3'b010;
      6'h04: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr(input int sel);
    logic [31:0] w;
    w = $urandom;
    case (sel)
      0: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
      2: begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
      3: begin w[31:26] = 6'h00; w[5:0] = 6'h27; end
      4: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
      5: w[31:26] = 6'h08;
      6: w[31:26] = 6'h0D;
      7: w[31:26] = 6'h0E;
      8: w[31:26] = 6'h23;
      9: w[31:26] = 6'h2B;
      10: w[31:26] = 6'h04;
      11: w[31:26] = 6'h3F;
      default: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  task automatic cyc(input string tag, input logic [13:0] e);
    @(negedge clk);
    chk({tag, " outputs"}, {18'b0, obs}, {18'b0, e});
    chk({tag, " outputs(cnt4)"}, {18'b0, obs4}, {18'b0, e});
    chk({tag, " instr_count"}, instr_count, cnt_m);
    chk({tag, " instr_count(cnt4)"}, {28'b0, cnt4}, {28'b0, cnt_m[3:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    instr_valid = 1'($urandom);
    instr       = $urandom;
    zero        = 1'($urandom);
    mem_ready   = 1'($urandom);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input int nw);
    int         c;
    logic [2:0] aop;
    logic       asrc;
    c    = model_cls(ins);
    aop  = model_aop(ins);
    asrc = (c == M_IALU) || (c == M_LW) || (c == M_SW);

    instr_valid = 1'b1;
    instr       = ins;
    zero        = 1'($urandom);
    mem_ready   = 1'($urandom);
    cyc("fetch", mk(3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    noise();
    cyc("decode", mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c == M_ILL));
    if (c == M_ILL) return;

    noise();
    if (c == M_BEQ) begin
      zero = z;
      cyc("exec beq", mk(3'b001, 0, 0, z, 1, 0, 0, 0, 0, 0, 1, 0));
      cnt_m++;
      return;
    end
    cyc("exec", mk(aop, asrc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    if (c == M_LW || c == M_SW) begin
      for (int k = 0; k <= nw; k++) begin
        noise();
        mem_ready = (k == nw);
        cyc("mem", mk(3'b000, 1, 0, 0, 0, 0, 0, 0, c == M_LW, c == M_SW,
                      (c == M_SW) && (k == nw), 0));
      end
      if (c == M_SW) begin
        cnt_m++;
        return;
      end
    end

    noise();
    cyc("wb", mk(3'b000, 0, 0, 0, 0, 1, c == M_R, c == M_LW, 0, 0, 1, 0));
    cnt_m++;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", '0);
    rst = 1'b0;
    cyc("idle", '0);

    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 1'b0, 0);
    chk("sub retired count", instr_count, 32'd1);
    instr_valid = 1'b0;
    cyc("idle after sub", '0);

    run_instr({6'h23, 5'd4, 5'd5, 16'h0010}, 1'b0, 2);
    run_instr({6'h04, 5'd1, 5'd1, 16'hFFFC}, 1'b1, 0);
    run_instr({6'h04, 5'd1, 5'd2, 16'h0008}, 1'b0, 0);
    run_instr({6'h3F, 26'h155_5555}, 1'b0, 0);
    chk("illegal leaves count", instr_count, 32'd4);

    // sw abandoned by reset while the write strobe is up
    instr_valid = 1'b1; instr = {6'h2B, 5'd6, 5'd7, 16'h0020};
    cyc("rst-sw fetch", mk(3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    noise();
    cyc("rst-sw decode", '0);
    noise();
    cyc("rst-sw exec", mk(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    noise(); mem_ready = 1'b0;
    cyc("rst-sw mem", mk(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; instr_valid = 1'b0; cnt_m = 0;
    cyc("after rst in mem", '0);

    // reset coinciding with a WB retire
    run_instr({6'h0D, 5'd1, 5'd2, 16'h00FF}, 1'b0, 0);
    instr_valid = 1'b1; instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    cyc("rst-wb fetch", mk(3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    noise();
    cyc("rst-wb decode", '0);
    noise();
    cyc("rst-wb exec", mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; instr_valid = 1'b0; cnt_m = 0;
    cyc("after rst in wb", '0);

    for (int i = 0; i < 16; i++) run_instr(gen_instr(6), 1'b0, 0);
    chk("cnt4 wrap to zero", {28'b0, cnt4}, 32'd0);
    chk("cnt32 after 16", instr_count, 32'd16);

    for (int i = 0; i < 80; i++)
      run_instr(gen_instr($urandom_range(0, 12)), 1'($urandom), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
